// File: rtl/i2c_bw_pkg.sv
// Shared types for the I2C burst writer: FSM states, SCL quarter-phase
// encoding and the R/W bit value used for write transactions.
package i2c_bw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    AACK  = 3'd3,
    DATA  = 3'd4,
    DACK  = 3'd5,
    STOP  = 3'd6
  } state_t;

  // Bit 1 of the phase doubles as the SCL level for data/ack bits.
  typedef enum logic [1:0] {
    PH_Q0 = 2'd0,
    PH_Q1 = 2'd1,
    PH_Q2 = 2'd2,
    PH_Q3 = 2'd3
  } phase_t;

  localparam logic I2C_WRITE_BIT = 1'b0;

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/bw_sync_fifo.sv
// Single-clock first-word-fall-through byte FIFO with occupancy and a sticky
// overflow flag. A push into a full FIFO is accepted when a pop happens too.
module bw_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic             overflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (wr_ptr == rd_ptr);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2c_burst_writer.sv
// Byte FIFO feeding an I2C master write engine: START, address byte, up to
// MAX_BURST data bytes with ACK checking, then STOP. Bit timing from a clock enable.
module i2c_burst_writer
  import i2c_bw_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CLK_DIV   = 125,
  parameter int MAX_BURST = 8,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        overflow,
  input  logic [6:0]  slave_addr,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        scl_o,
  output logic        sda_o,
  input  logic        sda_i
);

  localparam int          DW        = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [AW:0]   BURST_LIM = (AW+1)'(MAX_BURST);
  localparam logic [AW:0]   BURST_ONE = (AW+1)'(1);

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic [AW:0]   burst_cnt, burst_n;
  logic          sda_smp, sda_smp_n;
  logic          nack_n, done_n;
  logic          scl_n, sda_n;
  logic          tick, pop;
  logic [7:0]    head;

  bw_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .AW(AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr),
    .pop      (pop),
    .wdata    (wr_data),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

  // Next-state logic: every transition past IDLE happens on a tick.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_n     = bit_cnt;
    shift_n   = shift;
    burst_n   = burst_cnt;
    sda_smp_n = sda_smp;
    nack_n    = nack;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (go && !empty) begin
          state_n = START;
          phase_n = PH_Q0;
          bit_n   = 3'd0;
          shift_n = {slave_addr, I2C_WRITE_BIT};
          burst_n = '0;
          nack_n  = 1'b0;
        end else begin
          phase_n = PH_Q0;
        end
      end
      START, STOP: begin
        if (tick && phase == PH_Q1) begin
          state_n = (state == START) ? ADDR : IDLE;
          phase_n = PH_Q0;
          done_n  = (state == STOP);
        end else if (tick) begin
          phase_n = next_phase(phase);
        end else begin
          phase_n = phase;
        end
      end
      ADDR, DATA: begin
        if (tick && phase == PH_Q3) begin
          phase_n = PH_Q0;
          if (bit_cnt == 3'd7) begin
            bit_n   = 3'd0;
            state_n = (state == ADDR) ? AACK : DACK;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {shift[6:0], 1'b0};
          end
        end else if (tick) begin
          phase_n = next_phase(phase);
        end else begin
          phase_n = phase;
        end
      end
      AACK, DACK: begin
        if (tick && phase == PH_Q3) begin
          phase_n = PH_Q0;
          // sda_smp high means the slave left SDA released: NACK.
          if (sda_smp) begin
            nack_n  = 1'b1;
            state_n = STOP;
          end else if (state == AACK || (!empty && burst_cnt < BURST_LIM)) begin
            state_n = DATA;
            pop     = 1'b1;
            shift_n = head;
            burst_n = burst_cnt + BURST_ONE;
          end else begin
            state_n = STOP;
          end
        end else if (tick) begin
          phase_n = next_phase(phase);
          if (phase == PH_Q2) sda_smp_n = sda_i;
          else                sda_smp_n = sda_smp;
        end else begin
          phase_n = phase;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = PH_Q0;
      end
    endcase
  end

  // Bus levels derived from the upcoming state so the pins move with it.
  always_comb begin
    scl_n = 1'b1;
    sda_n = 1'b1;
    case (state_n)
      START: sda_n = (phase_n == PH_Q0);
      ADDR, DATA: begin
        scl_n = phase_n[1];
        sda_n = shift_n[7];
      end
      AACK, DACK: scl_n = phase_n[1];
      STOP: begin
        scl_n = (phase_n == PH_Q1);
        sda_n = 1'b0;
      end
      default: begin
        scl_n = 1'b1;
        sda_n = 1'b1;
      end
    endcase
  end

  // State, divider and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= PH_Q0;
      div_cnt   <= '0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      burst_cnt <= '0;
      sda_smp   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      div_cnt   <= (state == IDLE || tick) ? '0 : div_cnt + DIV_ONE;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      burst_cnt <= burst_n;
      sda_smp   <= sda_smp_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
      nack      <= nack_n;
      scl_o     <= scl_n;
      sda_o     <= sda_n;
    end
  end

endmodule

// File: tb/tb_i2c_burst_writer.sv
// Self-checking bench: open-drain bus with a slave ACKing 7'h50 only, and a
// queue-based model of the FIFO and of which bytes each transaction must carry.
module tb_i2c_burst_writer;

  localparam int DEPTH     = 16;
  localparam int CLK_DIV   = 4;
  localparam int MAX_BURST = 8;
  localparam int AW        = $clog2(DEPTH);
  localparam logic [6:0] ACK_ADDR = 7'h50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic [6:0]  slave_addr = 7'h00;
  logic        go = 1'b0;
  logic        full, empty, overflow, busy, done, nack, scl_o, sda_o, sda_i;
  logic [AW:0] level;

  logic s_drive = 1'b1;
  wire  sda_w = sda_o & s_drive;
  wire  scl_w = scl_o;
  assign sda_i = sda_w;

  i2c_burst_writer #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .slave_addr(slave_addr), .go(go), .busy(busy),
    .done(done), .nack(nack), .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic [7:0] exp_q[$];
  int         exp_n;
  logic       exp_nack;

  // Slave / monitor state.
  logic [7:0] rx_q[$];
  int   starts = 0, stops = 0, s_bit = 0, s_byte = 0;
  logic [7:0] s_sh = 8'h00;
  logic p_scl = 1'b1, p_sda = 1'b1, s_ack = 1'b0, s_match = 1'b0, s_active = 1'b0;

  int cyc = 0, g0 = 0, t_done = 0, done_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) t_done = cyc;
    end
  end

  // Slave sampled mid-cycle so simultaneous SCL/SDA moves are never misread.
  always @(negedge clk) begin
    if (rst) begin
      s_drive = 1'b1; s_active = 1'b0; s_ack = 1'b0; s_bit = 0;
    end else if (scl_w && p_scl && p_sda && !sda_w) begin
      starts++; s_active = 1'b1; s_bit = 0; s_byte = 0; s_ack = 1'b0;
    end else if (scl_w && p_scl && !p_sda && sda_w) begin
      stops++; s_active = 1'b0; s_drive = 1'b1;
    end else if (s_active && scl_w && !p_scl && s_bit < 8) begin
      s_sh = {s_sh[6:0], sda_w}; s_bit++;
    end else if (s_active && !scl_w && p_scl) begin
      if (s_ack) begin
        s_drive = 1'b1; s_ack = 1'b0; s_bit = 0; s_byte++;
      end else if (s_bit == 8) begin
        rx_q.push_back(s_sh);
        if (s_byte == 0) s_match = (s_sh[7:1] == ACK_ADDR);
        if (s_match) s_drive = 1'b0;
        s_ack = 1'b1;
      end
    end
    p_scl = scl_w;
    p_sda = sda_w;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_nack"}, nack, 1'b0);
    chk({tag, "_scl"}, scl_o, 1'b1);
    chk({tag, "_sda"}, sda_o, 1'b1);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic push(input logic [7:0] b);
    wr = 1'b1; wr_data = b;
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic start_txn(input logic [6:0] a);
    exp_q = {};
    exp_q.push_back({a, 1'b0});
    exp_nack = (a != ACK_ADDR);
    exp_n = 0;
    if (!exp_nack) begin
      while (mq.size() > 0 && exp_n < MAX_BURST) begin
        exp_q.push_back(mq.pop_front());
        exp_n++;
      end
    end
    rx_q = {}; starts = 0; stops = 0; done_cnt = 0;
    slave_addr = a; go = 1'b1; g0 = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic finish_txn(input string tag);
    int n = 0;
    int ticks;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
    repeat (8) @(negedge clk);
    // Half-bit START, 9-bit address+ack, 9 bits per data byte, half-bit STOP.
    ticks = 2 + 36 + 36 * exp_n + 2;
    chk_range({tag, "_duration"}, t_done - g0, ticks * CLK_DIV - CLK_DIV, ticks * CLK_DIV + CLK_DIV);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_nack"}, nack, exp_nack);
    chk({tag, "_starts"}, starts, 1);
    chk({tag, "_stops"}, stops, 1);
    chk({tag, "_level"}, level, mq.size());
    chk({tag, "_bus_idle"}, {scl_o, sda_o}, 2'b11);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int guard;
    logic [7:0] x;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst_init");
    rst = 1'b0;
    @(negedge clk);

    // go with an empty FIFO must not start anything.
    starts = 0; bad = 0;
    go = 1'b1; slave_addr = ACK_ADDR;
    repeat (2) @(negedge clk);
    go = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || !scl_o || !sda_o) bad++;
    end
    chk("empty_go_idle", bad, 0);
    chk("empty_go_starts", starts, 0);

    push(8'hA5);
    start_txn(ACK_ADDR);
    finish_txn("single");
    chk("single_empty", empty, 1'b1);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(6, 1);
      for (int k = 0; k < n; k++) push(8'($urandom));
      start_txn(ACK_ADDR);
      finish_txn($sformatf("rand%0d", r));
    end

    // Burst limit, with a go pulse during the transaction that must be ignored.
    for (int k = 0; k < 12; k++) push(8'(k));
    start_txn(ACK_ADDR);
    repeat (200) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    finish_txn("burst1");
    chk("burst1_level4", level, 4);
    start_txn(ACK_ADDR);
    finish_txn("burst2");

    push(8'($urandom));
    start_txn(7'h33);
    finish_txn("nack");
    chk("nack_level1", level, 1);
    start_txn(ACK_ADDR);
    finish_txn("nack_clear");

    // FIFO bounds and overflow.
    for (int k = 0; k < 17; k++) begin
      push(8'($urandom));
      if (k == 15) begin
        chk("fill16_full", full, 1'b1);
        chk("fill16_level", level, 16);
        chk("fill16_no_ovf", overflow, 1'b0);
      end
    end
    chk("fill17_full", full, 1'b1);
    chk("fill17_level", level, 16);
    chk("fill17_overflow", overflow, m_ovf);

    // Push held through the first pop: exactly one extra byte gets in.
    x = 8'($urandom);
    start_txn(ACK_ADDR);
    bad = 0;
    wr = 1'b1; wr_data = x;
    repeat (54 * CLK_DIV) begin
      @(negedge clk);
      if (level != 16) bad++;
    end
    wr = 1'b0;
    mq.push_back(x);
    chk("full_pushpop_level", bad, 0);
    finish_txn("full_txn");
    guard = 0;
    while (mq.size() > 0 && guard < 4) begin
      start_txn(ACK_ADDR);
      finish_txn($sformatf("drain%0d", guard));
      guard++;
    end
    chk("overflow_sticky", overflow, 1'b1);

    // Reset in the middle of a burst releases the bus at once.
    for (int k = 0; k < 4; k++) push(8'($urandom));
    start_txn(ACK_ADDR);
    repeat (150) @(negedge clk);
    chk("midburst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq = {}; m_ovf = 1'b0;
    @(negedge clk);
    chk_reset("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
